// File: rtl/dmux1to7_buf_if.sv
// dmux1to7_buf_if: producer/consumer bundle for the registered 1-to-N demultiplexer.
interface dmux1to7_buf_if #(
  parameter int WIDTH = 7,
  parameter int N     = 7,
  parameter int SELW  = 3
);
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [SELW-1:0]         sel;
  logic [0:N-1][WIDTH-1:0] out_data;
  logic [N-1:0]            out_valid;
  logic [N-1:0]            out_ready;
  logic                    sel_err;
  logic [7:0]              drop_cnt;
  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, sel_err, drop_cnt
  );
  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, sel_err, drop_cnt
  );
endinterface

// File: rtl/dmux1to7_buf.sv
// dmux1to7_buf: steers one word per cycle into one of N single-entry channel registers;
// out-of-range selects are always accepted, flagged and counted, then discarded.
module dmux1to7_buf #(
  parameter int WIDTH = 7,
  parameter int N     = 7,
  parameter int SELW  = 3
) (
  input logic clk,
  input logic rst,
  dmux1to7_buf_if.slave bus
);
  logic [N-1:0]            valid_q, valid_d;
  logic [0:N-1][WIDTH-1:0] data_q, data_d;
  logic                    err_q, err_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    sel_ok, accept;
  assign sel_ok       = int'(bus.sel) < N;
  // a full slot still accepts when its consumer drains it on the same edge
  assign bus.in_ready = sel_ok ? (!valid_q[bus.sel] || bus.out_ready[bus.sel]) : 1'b1;
  assign accept       = bus.in_valid && bus.in_ready;
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < N; i++) begin
      data_d[i]  = (accept && int'(bus.sel) == i) ? bus.in_data : data_q[i];
      valid_d[i] = (accept && int'(bus.sel) == i) ? 1'b1 :
                   (valid_q[i] && bus.out_ready[i]) ? 1'b0 : valid_q[i];
    end
    err_d = accept && !sel_ok;
    cnt_d = (err_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel_err   = err_q;
  assign bus.drop_cnt  = cnt_q;
endmodule
